// File: rtl/multi_port_data_ram_rr.sv
// multi_port_data_ram_rr: NUM_PORTS parallel read ports plus one shared write port.
// The write port is arbitrated round-robin; out-of-range accesses set a sticky error flag.
module multi_port_data_ram_rr #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 512,
   localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [NUM_PORTS-1:0]             rd_valid,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  rd_addr,
   output logic [NUM_PORTS-1:0]             rd_ready,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  rd_data,
   input  logic [NUM_PORTS-1:0]             wr_valid,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  wr_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wr_data,
   output logic [NUM_PORTS-1:0]             wr_ready,
   output logic                             oob_err,
   output logic [PW-1:0]                    oob_port,
   input  logic                             err_clr
);
   logic [DATA_WIDTH-1:0]           mem [DEPTH];
   logic [NUM_PORTS-1:0]            rd_ready_q, wr_ready_q, gnt_d, elig, rd_oob;
   logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [PW-1:0]                   rr_ptr_q, rr_ptr_d, gnt_idx, new_port, oob_port_q, oob_port_d;
   logic                            oob_err_q, oob_err_d, found, wr_oob, wr_en, oob_set;
   logic [ADDR_WIDTH-1:0]           wa;
   logic [DATA_WIDTH-1:0]           wd;
   int                              j;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return 64'(a) < 64'(DEPTH);
   endfunction

   // wr_ready_q doubles as the last_grant mask so a port still holding valid in its ready cycle is skipped
   always_comb begin
      elig = wr_valid & ~wr_ready_q;
      found = 1'b0;
      gnt_idx = '0;
      j = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= NUM_PORTS) j = j - NUM_PORTS;
         if (!found && elig[j]) begin
            found = 1'b1;
            gnt_idx = PW'(j);
         end
      end
   end

   assign wa     = wr_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign wd     = wr_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign wr_oob = found && !in_range(wa);
   assign wr_en  = found && !wr_oob;

   always_comb begin
      gnt_d = '0;
      gnt_d[gnt_idx] = found;
      rr_ptr_d = found ? ((int'(gnt_idx) == NUM_PORTS-1) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
   end

   always_comb begin
      rd_data_d = rd_data_q;
      rd_oob = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rd_oob[i] = rd_valid[i] && !in_range(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
         if (rd_valid[i])
            rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_oob[i] ? '0 : mem[rd_addr[i*ADDR_WIDTH +: IW]];
      end
   end

   // Lowest offending read port outranks the write; a set in the err_clr cycle wins
   always_comb begin
      new_port = gnt_idx;
      for (int i = NUM_PORTS-1; i >= 0; i--)
         if (rd_oob[i]) new_port = PW'(i);
      oob_set = (|rd_oob) || wr_oob;
      oob_err_d = oob_set || (oob_err_q && !err_clr);
      oob_port_d = (oob_set && (!oob_err_q || err_clr)) ? new_port : err_clr ? '0 : oob_port_q;
   end

   always_ff @(posedge clk)
      if (wr_en) mem[wa[IW-1:0]] <= wd;

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         rd_ready_q <= '0;
         rd_data_q  <= '0;
         wr_ready_q <= '0;
         rr_ptr_q   <= '0;
         oob_err_q  <= 1'b0;
         oob_port_q <= '0;
      end else begin
         rd_ready_q <= rd_valid;
         rd_data_q  <= rd_data_d;
         wr_ready_q <= gnt_d;
         rr_ptr_q   <= rr_ptr_d;
         oob_err_q  <= oob_err_d;
         oob_port_q <= oob_port_d;
      end

   assign rd_ready = rd_ready_q;
   assign rd_data  = rd_data_q;
   assign wr_ready = wr_ready_q;
   assign oob_err  = oob_err_q;
   assign oob_port = oob_port_q;
endmodule

// File: doc/multi_port_data_ram_rr.md
Name: multi_port_data_ram_rr

Overview:
- Parametrised successor to the GPU's fixed 4-port data RAM.
- Serves NUM_PORTS independent requesters, usually the GPU cores plus one PCIe host port on index 0.
- Every port gets its own read each cycle.
- Writes go through one physical write port, shared by round-robin arbitration instead of fixed priority, so no port can starve.
- Also adds read-data hold, out-of-range detection and a sticky error flag.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..16)
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 16, word-address width per port
- DEPTH, 512, number of words implemented; valid addresses are 0..DEPTH-1

Ports:
- clk  in  1  clock; all logic on the rising edge
- rstn  in  1  asynchronous active-low reset
- rd_valid  in  NUM_PORTS  per-port read request, one bit per port
- rd_addr  in  NUM_PORTS*ADDR_WIDTH  flattened read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_ready  out  NUM_PORTS  per-port one-cycle read-done pulse
- rd_data  out  NUM_PORTS*DATA_WIDTH  flattened read data; holds last value
- wr_valid  in  NUM_PORTS  per-port write request, held high until that port's wr_ready
- wr_addr  in  NUM_PORTS*ADDR_WIDTH  flattened write addresses
- wr_data  in  NUM_PORTS*DATA_WIDTH  flattened write data
- wr_ready  out  NUM_PORTS  per-port one-cycle write-done pulse, one-hot or zero
- oob_err  out  1  sticky: set by any out-of-range access
- oob_port  out  $clog2(NUM_PORTS) (minimum 1)  index of the first port that set oob_err
- err_clr  in  1  clears oob_err and oob_port

Behaviour:
- Reset (rstn low, asynchronous): rd_ready=0, wr_ready=0, rd_data=0 on all ports, oob_err=0, oob_port=0, rr_ptr=0, last_grant mask=0. RAM contents are not reset. Reset in the middle of a transaction drops it silently; requesters must re-issue.
- Reads:
  - Port i with rd_valid[i]=1 in cycle t gets rd_ready[i]=1 in cycle t+1, with rd_data slice i = RAM[rd_addr_i] sampled at edge t.
  - rd_ready[i] is 0 whenever rd_valid[i] was 0.
  - rd_data slice i holds its last value while rd_ready[i]=0; it is never zeroed.
  - Reads are fully parallel with no arbitration.
  - Back-to-back reads give one result per cycle.
- Read-during-write to the same address in the same cycle is read-first: the read returns the old data, and the new data is visible from cycle t+1.
- Write arbitration:
  - Each cycle, eligible = wr_valid & ~last_grant.
  - Masking last_grant prevents a double write while the granted port still holds wr_valid during its wr_ready cycle.
  - The grant goes to the first eligible port scanning upward from rr_ptr and wrapping past NUM_PORTS-1 to 0.
  - On grant g at edge t:
    - RAM[wr_addr_g] <= wr_data_g
    - wr_ready[g]=1 in cycle t+1
    - rr_ptr <= (g+1) mod NUM_PORTS
    - last_grant <= onehot(g)
  - With no eligible port: no write, wr_ready=0, last_grant=0, rr_ptr unchanged.
  - Worst-case write latency for a held request is NUM_PORTS cycles from the request to wr_ready.
- Out-of-range (address >= DEPTH):
  - A read returns 0 with rd_ready pulsed normally.
  - A granted write is dropped, and wr_ready is still pulsed so the requester does not hang.
  - Either case sets oob_err=1 in the following cycle.
  - oob_port latches the offending port only if oob_err was 0. If several ports hit out-of-range at once, the lowest index wins, reads before writes.
- Error clear:
  - err_clr=1 clears oob_err and oob_port in the next cycle.
  - If a new out-of-range access arrives in the same cycle as err_clr, the set wins and oob_port takes the new port.
- The RAM must infer as block RAM when NUM_PORTS<=2; otherwise a register array is acceptable.

Test Plan:
- NUM_PORTS=4: write port 2 with addr 0x0010, data 0xDEADBEEF; next cycle read the same address on ports 0..3 together -> the write gets wr_ready[2] one cycle later; all four rd_data slices are 0xDEADBEEF one cycle after the read, with rd_ready=4'b1111.
- wr_valid=4'b1111 held until each port's ready, addr=port index, data=0x100+index, rr_ptr=0 -> wr_ready pulses are one-hot in order port 0,1,2,3 on 4 consecutive cycles (no duplicates); RAM[0..3]=0x100..0x103.
- Port 1 holds wr_valid continuously, re-issuing after each ready; port 3 requests once -> port 3 is granted within 2 cycles of its request (no starvation).
- Same-cycle write of 0x5 and read of addr 7 containing 0x9 -> read returns 0x9; a read in the next cycle returns 0x5.
- Read on port 2 to addr 512 with DEPTH=512 -> rd_data slice 2 = 0, rd_ready[2]=1, oob_err=1, oob_port=2. Then an out-of-range write on port 0 -> oob_port stays 2. Then err_clr -> oob_err=0, oob_port=0.
- Assert rstn low while wr_valid=4'b0110 is pending -> all ready outputs=0, rd_data=0, rr_ptr=0. After release, arbitration restarts from port 0: port 1 is granted first.
